register_bank: RTL

//  Parametrised integer register file for the RISC-V datapath. N registered read ports, one write

---
 rtl/regbank_pkg.sv | 12 +
 rtl/regbank_dump_fsm.sv | 60 ++++++
 rtl/register_bank.sv | 104 ++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared defaults, reset constants and dump-state encoding for the integer register bank.
package regbank_pkg;
  localparam int          DATA_W_DEF   = 32;
  localparam int          NUM_REGS_DEF = 32;
  localparam int unsigned RESET_X1     = 1;
  localparam int unsigned RESET_X29    = 252;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_e;
endpackage

// File: rtl/regbank_dump_fsm.sv
// Sequential register dump: walks indices 0..NUM_REGS-1 over a valid/ready stream.
// Each beat is a snapshot captured on the previous handshake, so it stays stable while stalled.
module regbank_dump_fsm
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ready,
  output logic              busy,
  output logic              valid,
  output logic              last,
  output logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e state;

  // Index of the register the next captured beat will present.
  always_comb begin
    rd_idx = '0;
    if (state == SEND) rd_idx = idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SEND;
          idx   <= '0;
          data  <= rd_data;
        end
        SEND: if (ready) begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
          end else begin
            idx  <= idx + 1'b1;
            data <= rd_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == SEND);
  assign valid = busy;
  assign last  = busy && (idx == LAST_IDX);
endmodule

// File: rtl/register_bank.sv
// Integer register file: NUM_RD registered read ports, one write port, optional bypass,
// hardwired x0, programmable reset values and a streamed debug dump.
module register_bank
  import regbank_pkg::*;
#(
  parameter int          DATA_W     = DATA_W_DEF,
  parameter int          NUM_REGS   = NUM_REGS_DEF,
  parameter int          ADDR_W     = $clog2(NUM_REGS),
  parameter int          NUM_RD     = 2,
  parameter int          BYPASS     = 1,
  parameter int          ZERO_REG   = 1,
  parameter int          INIT_IDX_A = 1,
  parameter int unsigned INIT_VAL_A = RESET_X1,
  parameter int          INIT_IDX_B = 29,
  parameter int unsigned INIT_VAL_B = RESET_X29
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rdEn,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  output logic [NUM_RD-1:0]        rdValid,
  input  logic                     wrEn,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     dumpStart,
  output logic                     dumpBusy,
  output logic                     dumpValid,
  input  logic                     dumpReady,
  output logic [ADDR_W-1:0]        dumpIdx,
  output logic [DATA_W-1:0]        dumpData,
  output logic                     dumpLast
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // One lookup rule for every reader: x0 first, then same-cycle write bypass, then storage.
  function automatic logic [DATA_W-1:0] lookup(
    input logic [ADDR_W-1:0]                a,
    input logic [NUM_REGS-1:0][DATA_W-1:0] r,
    input logic                             we,
    input logic [ADDR_W-1:0]                wa,
    input logic [DATA_W-1:0]                wd
  );
    if (ZERO_REG != 0 && a == '0) return '0;
    if (BYPASS != 0 && we && wa == a) return wd;
    return r[a];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == INIT_IDX_A)      regs[i] <= DATA_W'(INIT_VAL_A);
        else if (i == INIT_IDX_B) regs[i] <= DATA_W'(INIT_VAL_B);
        else                      regs[i] <= '0;
      end
    end else if (wrEn && !(ZERO_REG != 0 && wrAddr == '0)) begin
      regs[wrAddr] <= wrData;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;
    logic              v;

    assign a = rdAddr[p*ADDR_W +: ADDR_W];

    always_ff @(posedge clk) begin
      if (!reset) begin
        q <= '0;
        v <= 1'b0;
      end else begin
        v <= rdEn[p];
        if (rdEn[p]) q <= lookup(a, regs, wrEn, wrAddr, wrData);
      end
    end

    assign rdData[p*DATA_W +: DATA_W] = q;
    assign rdValid[p]                 = v;
  end

  logic [ADDR_W-1:0] dump_rd_idx;
  logic [DATA_W-1:0] dump_rd_data;

  assign dump_rd_data = lookup(dump_rd_idx, regs, wrEn, wrAddr, wrData);

  regbank_dump_fsm #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dump (
    .clk     (clk),
    .reset   (reset),
    .start   (dumpStart),
    .ready   (dumpReady),
    .busy    (dumpBusy),
    .valid   (dumpValid),
    .last    (dumpLast),
    .idx     (dumpIdx),
    .data    (dumpData),
    .rd_idx  (dump_rd_idx),
    .rd_data (dump_rd_data)
  );
endmodule
